// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: control-flow front end for the program counter.
// Decodes JMP/CALL/RET ops from the fetch stage. Drives a one-cycle load
// strobe plus load value to the counter. Keeps a LIFO return-address stack
// so CALL/RET pairs nest. After every redirect, fetch is held off for
// FLUSH_CYC cycles so that stale instructions are flushed.
//
// Optional build macro STK_ERR_TRAP_EN: a stack overflow or underflow also
// redirects to TRAP_ADDR and runs the flush sequence.
//
// Ports:
//   clk, rstn             clock (rising edge), async active-low reset
//   instr_valid/ready     op handshake; ready is low while flushing
//   instr_op              00 NOP, 01 JMP, 10 CALL, 11 RET
//   instr_target          JMP/CALL destination
//   pc                    address of the presented op
//   err_clr               clears the sticky error flags
//   cnt_load, cnt_val     registered load strobe and value to the counter
//   stk_depth             number of live stack entries
//   stk_ovf, stk_unf      sticky: CALL while full / RET while empty
module pc_branch_ctrl #(
  parameter int unsigned     AW        = 5,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     FLUSH_CYC = 1,
  parameter logic [AW-1:0]   TRAP_ADDR = 5'd31
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [1:0]               instr_op,
  input  logic [AW-1:0]            instr_target,
  input  logic [AW-1:0]            pc,
  input  logic                     err_clr,
  output logic                     cnt_load,
  output logic [AW-1:0]            cnt_val,
  output logic [$clog2(DEPTH):0]   stk_depth,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = PW + 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [2:0]      flush_cnt, flush_nxt;
  logic [AW-1:0]   stk_mem [DEPTH];

  logic            accept;
  logic            full, empty;
  logic [PW-1:0]   push_idx, pop_idx;
  logic            do_load, push, pop, set_ovf, set_unf;
  logic [AW-1:0]   load_val;

  assign accept   = instr_valid & instr_ready;
  assign full     = (stk_depth == DW'(DEPTH));
  assign empty    = (stk_depth == '0);
  // Low bits of the depth address the memory. When the stack is full the low
  // bits wrap to 0, so subtracting 1 still selects the top entry.
  assign push_idx = stk_depth[PW-1:0];
  assign pop_idx  = stk_depth[PW-1:0] - PW'(1);

  // Op decode
  always_comb begin
    do_load  = 1'b0;
    load_val = TRAP_ADDR;
    push     = 1'b0;
    pop      = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (accept) begin
      case (instr_op)
        2'b01: begin
          do_load  = 1'b1;
          load_val = instr_target;
        end
        2'b10: begin
          if (full) begin
            set_ovf = 1'b1;
`ifdef STK_ERR_TRAP_EN
            do_load = 1'b1;
`endif
          end else begin
            push     = 1'b1;
            do_load  = 1'b1;
            load_val = instr_target;
          end
        end
        2'b11: begin
          if (empty) begin
            set_unf = 1'b1;
`ifdef STK_ERR_TRAP_EN
            do_load = 1'b1;
`endif
          end else begin
            pop      = 1'b1;
            do_load  = 1'b1;
            load_val = stk_mem[pop_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    case (state)
      IDLE: begin
        if (do_load && (FLUSH_CYC != 0)) begin
          state_nxt = FLUSH;
          flush_nxt = 3'(FLUSH_CYC);
        end
      end
      FLUSH: begin
        flush_nxt = flush_cnt - 3'd1;
        if (flush_cnt == 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    instr_ready = (state == IDLE);
  end

  // Registered load outputs, stack depth and sticky flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_load  <= 1'b0;
      cnt_val   <= '0;
      stk_depth <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
    end else begin
      cnt_load <= do_load;
      if (do_load) cnt_val <= load_val;
      if (push)     stk_depth <= stk_depth + DW'(1);
      else if (pop) stk_depth <= stk_depth - DW'(1);
      // A new error wins over a coincident clear
      if (set_ovf)      stk_ovf <= 1'b1;
      else if (err_clr) stk_ovf <= 1'b0;
      if (set_unf)      stk_unf <= 1'b1;
      else if (err_clr) stk_unf <= 1'b0;
    end
  end

  // Stack storage has no reset; emptiness is tracked by stk_depth alone
  always_ff @(posedge clk) begin
    if (push) stk_mem[push_idx] <= pc + AW'(1);
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 4;
`ifdef STK_ERR_TRAP_EN
  localparam int TRAP = 1;
`else
  localparam int TRAP = 0;
`endif

  localparam logic [1:0] NOP = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_target;
  logic [AW-1:0] pc;
  logic          err_clr;
  logic          cnt_load;
  logic [AW-1:0] cnt_val;
  logic [2:0]    stk_depth;
  logic          stk_ovf;
  logic          stk_unf;

  int n_cmp = 0;
  int n_err = 0;

  pc_branch_ctrl #(
    .AW        (AW),
    .DEPTH     (DEPTH),
    .FLUSH_CYC (1),
    .TRAP_ADDR (5'd31)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_target (instr_target),
    .pc           (pc),
    .err_clr      (err_clr),
    .cnt_load     (cnt_load),
    .cnt_val      (cnt_val),
    .stk_depth    (stk_depth),
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for exactly one edge
  task automatic send(input logic [1:0] op, input int tgt, input int p);
    instr_valid  = 1'b1;
    instr_op     = op;
    instr_target = AW'(tgt);
    pc           = AW'(p);
    step();
    instr_valid  = 1'b0;
    instr_op     = NOP;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    check("rst_ready", int'(instr_ready), 1);
    check("rst_load",  int'(cnt_load), 0);
    check("rst_depth", int'(stk_depth), 0);
    step();
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ret[4];
    int call_pc[4];
    rstn = 1'b0; instr_valid = 1'b0; instr_op = NOP;
    instr_target = '0; pc = '0; err_clr = 1'b0;
    #2;
    check("rst_ready", int'(instr_ready), 1);
    check("rst_load",  int'(cnt_load), 0);
    check("rst_val",   int'(cnt_val), 0);
    check("rst_depth", int'(stk_depth), 0);
    check("rst_ovf",   int'(stk_ovf), 0);
    check("rst_unf",   int'(stk_unf), 0);
    step();
    rstn = 1'b1;
    step();

    // NOP: no effect
    send(NOP, 7, 2);
    check("nop_load",  int'(cnt_load), 0);
    check("nop_ready", int'(instr_ready), 1);

    // JMP 12 at pc 3
    send(JMP, 12, 3);
    check("jmp_load",  int'(cnt_load), 1);
    check("jmp_val",   int'(cnt_val), 12);
    check("jmp_ready", int'(instr_ready), 0);
    check("jmp_depth", int'(stk_depth), 0);
    step();
    check("jmp_ready2", int'(instr_ready), 1);
    check("jmp_load2",  int'(cnt_load), 0);

    // CALL 20 at pc 5, RET at pc 22
    send(CALL, 20, 5);
    check("call_val",   int'(cnt_val), 20);
    check("call_load",  int'(cnt_load), 1);
    check("call_depth", int'(stk_depth), 1);
    step();
    send(RET, 0, 22);
    check("ret_val",   int'(cnt_val), 6);
    check("ret_load",  int'(cnt_load), 1);
    check("ret_depth", int'(stk_depth), 0);
    step();

    // Four nested calls, four returns, then underflow
    call_pc = '{1, 10, 11, 12};
    exp_ret = '{13, 12, 11, 2};
    foreach (call_pc[i]) begin
      send(CALL, 10 + i, call_pc[i]);
      step();
    end
    check("nest_depth", int'(stk_depth), 4);
    foreach (exp_ret[i]) begin
      send(RET, 0, 25);
      check($sformatf("nest_ret%0d", i), int'(cnt_val), exp_ret[i]);
      check($sformatf("nest_dep%0d", i), int'(stk_depth), 3 - i);
      step();
    end
    send(RET, 0, 25);
    check("unf_flag",  int'(stk_unf), 1);
    check("unf_load",  int'(cnt_load), TRAP);
    check("unf_depth", int'(stk_depth), 0);
    if (TRAP != 0) check("unf_trap", int'(cnt_val), 31);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("unf_clr", int'(stk_unf), 0);

    // Five calls: fifth overflows
    for (int i = 0; i < 4; i++) begin
      send(CALL, 7, i);
      step();
    end
    send(CALL, 7, 4);
    check("ovf_flag",  int'(stk_ovf), 1);
    check("ovf_load",  int'(cnt_load), TRAP);
    check("ovf_depth", int'(stk_depth), 4);
    check("ovf_ready", int'(instr_ready), 1 - TRAP);
    if (TRAP != 0) check("ovf_trap", int'(cnt_val), 31);
    step();
    check("ovf_sticky", int'(stk_ovf), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_clr", int'(stk_ovf), 0);

    // Return address wraps at top of address space
    do_reset();
    send(CALL, 4, 31);
    check("wrap_call", int'(cnt_val), 4);
    check("wrap_dep",  int'(stk_depth), 1);
    step();
    send(RET, 0, 4);
    check("wrap_ret", int'(cnt_val), 0);
    step();

    // Async reset mid-FLUSH
    send(CALL, 9, 7);
    check("fl_ready", int'(instr_ready), 0);
    check("fl_depth", int'(stk_depth), 1);
    rstn = 1'b0;
    #1;
    check("ar_ready", int'(instr_ready), 1);
    check("ar_load",  int'(cnt_load), 0);
    check("ar_depth", int'(stk_depth), 0);
    step();
    rstn = 1'b1;
    send(RET, 0, 9);
    check("ar_unf",  int'(stk_unf), 1);
    check("ar_load2", int'(cnt_load), TRAP);
    step();

    // err_clr coinciding with a new underflow: set wins
    err_clr = 1'b1;
    send(RET, 0, 9);
    err_clr = 1'b0;
    check("clr_vs_set", int'(stk_unf), 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Control-flow front end for the 5-bit program counter.
- Decodes jump/call/return requests from the fetch stage and drives the counter's load strobe and load value.
- Keeps a LIFO return-address stack so CALL/RET pairs nest.
- Blocks fetch for a fixed number of cycles after each redirect so stale instructions are flushed.

Parameters:
- AW, 5, address width; matches counter width.
- DEPTH, 4, return-stack entries (power of 2, >=2).
- FLUSH_CYC, 1, cycles instr_ready stays low after a redirect (0..7).
- TRAP_ADDR, 5'd31, trap vector used only with STK_ERR_TRAP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- instr_valid  in  1  fetch stage presents a control op.
- instr_ready  out  1  block accepts an op this cycle.
- instr_op  in  2  00 NOP, 01 JMP, 10 CALL, 11 RET.
- instr_target  in  AW  jump/call destination.
- pc  in  AW  current counter value (address of the presented op).
- err_clr  in  1  clears sticky error flags.
- cnt_load  out  1  one-cycle load strobe to the counter.
- cnt_val  out  AW  value to load; valid when cnt_load=1.
- stk_depth  out  log2(DEPTH)+1  current number of stack entries.
- stk_ovf  out  1  sticky: CALL issued with stack full.
- stk_unf  out  1  sticky: RET issued with stack empty.

Behaviour:
- Reset: outputs cnt_load=0, cnt_val=0, stk_depth=0, stk_ovf=0, stk_unf=0, instr_ready=1. State is IDLE, flush counter is 0. Stack contents are don't-care.
- Accept: an op is accepted when instr_valid & instr_ready at a rising edge. NOP is accepted with no effect.
- Outputs are registered. cnt_load/cnt_val appear in the cycle after acceptance and cnt_load is high for exactly one cycle.
- JMP: cnt_val <= instr_target; cnt_load <= 1; stack unchanged.
- CALL, not full: push (pc+1) mod 2^AW; depth+1; cnt_val <= instr_target; cnt_load <= 1.
- CALL, full: no push, no load, stk_ovf <= 1; depth unchanged.
- RET, not empty: pop; cnt_val <= popped entry; cnt_load <= 1; depth-1.
- RET, empty: no load, stk_unf <= 1.
- FSM states are IDLE and FLUSH.
  - IDLE: instr_ready=1. An accepted op that asserts cnt_load moves to FLUSH with counter=FLUSH_CYC, or stays in IDLE if FLUSH_CYC=0.
  - FLUSH: instr_ready=0; counter decrements each cycle; return to IDLE when it reaches 1 → 0. Inputs are ignored in FLUSH.
- FLUSH_CYC=0: back-to-back redirects are legal and cnt_load may be high on consecutive cycles.
- Ops that produce no load (NOP, error cases) never enter FLUSH.
- Wrap: pc=2^AW-1 with CALL pushes 0.
- err_clr: clears both sticky flags next edge. If err_clr coincides with a new error, the set wins.
- Reset mid-FLUSH or with a pending load: everything returns to reset values immediately (async); stack is emptied via depth=0.
- Sticky flags never clear except by err_clr or rstn.

Optional Feature:
- Macro: STK_ERR_TRAP_EN.
- Defined: CALL-when-full and RET-when-empty also redirect. cnt_val <= TRAP_ADDR, cnt_load <= 1, the FLUSH sequence runs, and the sticky flag is set as usual. The stack is unchanged.
- Undefined: errors only set flags. There is no redirect and no FLUSH.

Test Plan (AW=5, DEPTH=4, FLUSH_CYC=1):
- Reset, then JMP target=12 at pc=3 → next cycle cnt_load=1, cnt_val=12; instr_ready=0 for 1 cycle, then 1; depth=0.
- CALL target=20 at pc=5, then RET at pc=22 → first redirect cnt_val=20, depth=1; RET gives cnt_val=6, depth=0.
- Four nested CALLs at pc=1,10,11,12 then four RETs → pops return 13,12,11,2 in order; fifth RET → stk_unf=1, no cnt_load.
- Five CALLs with no RET → fifth: stk_ovf=1, no cnt_load, depth=4. err_clr → flags 0 next cycle. With STK_ERR_TRAP_EN: fifth CALL gives cnt_load=1, cnt_val=31.
- CALL at pc=31 target=4, then RET → pushed/returned value 0.
- Assert rstn=0 during FLUSH after a CALL → instr_ready=1, cnt_load=0, depth=0 immediately. A following RET → stk_unf=1.
